// File: rtl/fcvt_w_s_pipe.sv
// Two-stage binary32 -> signed int32 converter (FCVT.W.S) with all static rounding
// modes, saturating results and NV/NX flags. A global stall freezes both stages.
module fcvt_w_s_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic [2:0]  rm,
    input  logic        in_valid,
    input  logic        stall,
    output logic [31:0] y,
    output logic        out_valid,
    output logic        nv,
    output logic        nx
);

    logic        w_s;
    logic [7:0]  w_e;
    logic [22:0] w_f;
    logic        w_nan, w_inf, w_zero, w_den, w_ovf, w_left;
    logic [4:0]  w_sh;

    logic        r1_valid, r1_s, r1_nan, r1_inf, r1_zero, r1_den, r1_ovf, r1_left;
    logic [2:0]  r1_rm;
    logic [23:0] r1_sig;
    logic [4:0]  r1_sh;

    assign w_s    = x[31];
    assign w_e    = x[30:23];
    assign w_f    = x[22:0];
    assign w_nan  = (&w_e) & (|w_f);
    assign w_inf  = (&w_e) & ~(|w_f);
    assign w_zero = ~(|w_e) & ~(|w_f);
    assign w_den  = ~(|w_e) & (|w_f);
    // -2^31 is the one value with e >= 158 that still fits.
    assign w_ovf  = (w_e >= 8'd158) & (x != 32'hCF00_0000);
    assign w_left = (w_e >= 8'd150);

    always_comb begin
        w_sh = 5'd0;
        if (w_left)
            w_sh = 5'(w_e - 8'd150);
        else if (w_e < 8'd120)
            w_sh = 5'd31;
        else
            w_sh = 5'(8'd150 - w_e);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1_valid <= 1'b0;
            r1_s     <= 1'b0;
            r1_rm    <= 3'd0;
            r1_sig   <= 24'd0;
            r1_nan   <= 1'b0;
            r1_inf   <= 1'b0;
            r1_zero  <= 1'b0;
            r1_den   <= 1'b0;
            r1_ovf   <= 1'b0;
            r1_left  <= 1'b0;
            r1_sh    <= 5'd0;
        end else if (!stall) begin
            r1_valid <= in_valid;
            r1_s     <= w_s;
            r1_rm    <= rm;
            r1_sig   <= {1'b1, w_f};
            r1_nan   <= w_nan;
            r1_inf   <= w_inf;
            r1_zero  <= w_zero;
            r1_den   <= w_den;
            r1_ovf   <= w_ovf;
            r1_left  <= w_left;
            r1_sh    <= w_sh;
        end
    end

    logic [55:0] w_ext;
    logic [32:0] w_mag, w_r;
    logic        w_guard, w_sticky, w_inc, w_in_range;
    logic [31:0] w_y;
    logic        w_nv, w_nx;

    // Significand sits above 32 zero bits so guard/sticky fall out of the same shift.
    assign w_ext = {r1_sig, 32'd0} >> r1_sh;

    always_comb begin
        w_mag    = 33'd0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        if (r1_den) begin
            w_sticky = 1'b1;
        end else if (r1_left) begin
            w_mag = {9'd0, r1_sig} << r1_sh;
        end else begin
            w_mag    = {9'd0, w_ext[55:32]};
            w_guard  = w_ext[31];
            w_sticky = |w_ext[30:0];
        end
    end

    always_comb begin
        case (r1_rm)
            3'd1:    w_inc = 1'b0;
            3'd2:    w_inc = r1_s & (w_guard | w_sticky);
            3'd3:    w_inc = ~r1_s & (w_guard | w_sticky);
            3'd4:    w_inc = w_guard;
            default: w_inc = w_guard & (w_sticky | w_mag[0]);
        endcase
    end

    assign w_r        = w_mag + {32'd0, w_inc};
    assign w_in_range = r1_s ? (w_r <= 33'h0_8000_0000) : (w_r <= 33'h0_7FFF_FFFF);

    always_comb begin
        w_y  = 32'd0;
        w_nv = 1'b0;
        w_nx = 1'b0;
        if (r1_nan) begin
            w_y  = 32'h7FFF_FFFF;
            w_nv = 1'b1;
        end else if (r1_inf || r1_ovf || !w_in_range) begin
            w_y  = r1_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            w_nv = 1'b1;
        end else if (!r1_zero) begin
            w_y  = r1_s ? (32'd0 - w_r[31:0]) : w_r[31:0];
            w_nx = w_guard | w_sticky;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            y         <= 32'd0;
            nv        <= 1'b0;
            nx        <= 1'b0;
        end else if (!stall) begin
            out_valid <= r1_valid;
            if (r1_valid) begin
                y  <= w_y;
                nv <= w_nv;
                nx <= w_nx;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_w_s_pipe.sv
// Bench for fcvt_w_s_pipe: directed vector table, stall/reset sequences and a
// randomized stream scored against an arithmetic reference model.
module tb_fcvt_w_s_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] x;
    logic [2:0]  rm;
    logic        in_valid;
    logic        stall;
    logic [31:0] y;
    logic        out_valid;
    logic        nv;
    logic        nx;

    int total = 0;
    int bad   = 0;

    fcvt_w_s_pipe dut (
        .clk       (clk),
        .rstn      (rstn),
        .x         (x),
        .rm        (rm),
        .in_valid  (in_valid),
        .stall     (stall),
        .y         (y),
        .out_valid (out_valid),
        .nv        (nv),
        .nx        (nx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [2:0]  rm;
        logic [31:0] y;
        logic        nv;
        logic        nx;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic        nv;
        logic        nx;
    } res_t;

    vec_t vecs[21];
    res_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact value = sig * 2^(e-150); round the magnitude by comparing the
    // discarded fraction against one half, then range-check as a signed integer.
    function automatic void ref_model(input logic [31:0] xx, input logic [2:0] rmi,
                                      output logic [31:0] ey, output logic env, output logic enx);
        logic   s;
        int     e, k, cat, mode;
        longint sig, q, rem, pw, val, one;
        logic   up;
        longint maxi = 64'sd2147483647;
        longint mini = -64'sd2147483648;
        one = 1;
        s   = xx[31];
        e   = int'(xx[30:23]);
        sig = 0;
        sig[23:0] = {1'b1, xx[22:0]};
        mode = (rmi > 3'd4) ? 0 : int'(rmi);
        ey = 32'd0; env = 1'b0; enx = 1'b0;
        if (e == 255) begin
            env = 1'b1;
            ey  = (xx[22:0] != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
            return;
        end
        if (e == 0 && xx[22:0] == 0) return;
        if (e == 0) begin
            q = 0; cat = 1;
        end else if (e >= 190) begin
            q = one << 40; cat = 0;
        end else if (e >= 150) begin
            q = sig * (one << (e - 150)); cat = 0;
        end else begin
            k = 150 - e;
            if (k > 40) begin
                q = 0; cat = 1;
            end else begin
                pw  = one << k;
                q   = sig / pw;
                rem = sig % pw;
                if (rem == 0)           cat = 0;
                else if (rem < pw / 2)  cat = 1;
                else if (rem == pw / 2) cat = 2;
                else                    cat = 3;
            end
        end
        case (mode)
            1:       up = 1'b0;
            2:       up = s && cat != 0;
            3:       up = !s && cat != 0;
            4:       up = cat >= 2;
            default: up = (cat == 3) || (cat == 2 && q[0]);
        endcase
        if (up) q = q + 1;
        val = s ? -q : q;
        if (val > maxi || val < mini) begin
            env = 1'b1;
            ey  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            ey  = val[31:0];
            enx = (cat != 0);
        end
    endfunction

    function automatic logic [31:0] gen_x();
        logic [31:0] r;
        logic [31:0] picks[8];
        picks = '{32'h0000_0000, 32'h8000_0001, 32'hCF00_0000, 32'h4EFF_FFFF,
                  32'h4F00_0000, 32'hCF00_0001, 32'h3F00_0000, 32'hC0A0_0000};
        r = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: r[30:23] = 8'($urandom_range(100, 160));
            2: begin
                r[30:23] = 8'($urandom_range(125, 152));
                r[19:0]  = 20'd0;
            end
            default: r = picks[$urandom_range(0, 7)];
        endcase
        return r;
    endfunction

    int          lat;
    logic [31:0] cy;
    logic        cnv, cnx;

    initial begin
        vecs[0]  = '{32'h3FC0_0000, 3'd0, 32'h0000_0002, 1'b0, 1'b1};
        vecs[1]  = '{32'h3FC0_0000, 3'd1, 32'h0000_0001, 1'b0, 1'b1};
        vecs[2]  = '{32'h3FC0_0000, 3'd2, 32'h0000_0001, 1'b0, 1'b1};
        vecs[3]  = '{32'h3FC0_0000, 3'd3, 32'h0000_0002, 1'b0, 1'b1};
        vecs[4]  = '{32'h3FC0_0000, 3'd4, 32'h0000_0002, 1'b0, 1'b1};
        vecs[5]  = '{32'hC020_0000, 3'd0, 32'hFFFF_FFFE, 1'b0, 1'b1};
        vecs[6]  = '{32'hC020_0000, 3'd1, 32'hFFFF_FFFE, 1'b0, 1'b1};
        vecs[7]  = '{32'hC020_0000, 3'd2, 32'hFFFF_FFFD, 1'b0, 1'b1};
        vecs[8]  = '{32'hC020_0000, 3'd3, 32'hFFFF_FFFE, 1'b0, 1'b1};
        vecs[9]  = '{32'hC020_0000, 3'd4, 32'hFFFF_FFFD, 1'b0, 1'b1};
        vecs[10] = '{32'hCF00_0000, 3'd0, 32'h8000_0000, 1'b0, 1'b0};
        vecs[11] = '{32'h4F00_0000, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[12] = '{32'h7FC0_0000, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[13] = '{32'hFF80_0000, 3'd0, 32'h8000_0000, 1'b1, 1'b0};
        vecs[14] = '{32'h4EFF_FFFF, 3'd0, 32'h7FFF_FF80, 1'b0, 1'b0};
        vecs[15] = '{32'h0000_0001, 3'd3, 32'h0000_0001, 1'b0, 1'b1};
        vecs[16] = '{32'h0000_0001, 3'd0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[17] = '{32'h8000_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[18] = '{32'hBF00_0000, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[19] = '{32'hBF00_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[20] = '{32'h3FC0_0000, 3'd6, 32'h0000_0002, 1'b0, 1'b1};

        rstn = 1'b0; x = 32'd0; rm = 3'd0; in_valid = 1'b0; stall = 1'b0;
        #2;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_y", y, 32'd0);
        check("reset_flags", {30'd0, nv, nx}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            x = vecs[i].x; rm = vecs[i].rm; in_valid = 1'b1;
            lat = -1; cy = 32'd0; cnv = 1'b0; cnx = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (lat < 0 && out_valid) begin
                    lat = c; cy = y; cnv = nv; cnx = nx;
                end
            end
            check($sformatf("vec%0d_latency", i), lat, 32'd2);
            check($sformatf("vec%0d_y", i), cy, vecs[i].y);
            check($sformatf("vec%0d_nv", i), {31'd0, cnv}, {31'd0, vecs[i].nv});
            check($sformatf("vec%0d_nx", i), {31'd0, cnx}, {31'd0, vecs[i].nx});
        end

        // Back-to-back 1.0, 2.0, 3.0 with a three-edge stall after the first result.
        @(negedge clk);
        x = 32'h3F80_0000; rm = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        x = 32'h4000_0000;
        @(negedge clk);
        check("thru_first_valid", {31'd0, out_valid}, 32'd1);
        check("thru_first_y", y, 32'd1);
        x = 32'h4040_0000; stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold_y", y, 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("thru_second_valid", {31'd0, out_valid}, 32'd1);
        check("thru_second_y", y, 32'd2);
        @(negedge clk);
        check("thru_third_valid", {31'd0, out_valid}, 32'd1);
        check("thru_third_y", y, 32'd3);
        @(negedge clk);
        check("thru_drain_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with two operations in flight.
        @(negedge clk);
        x = 32'h4080_0000; in_valid = 1'b1;
        @(negedge clk);
        x = 32'h40A0_0000;
        @(negedge clk);
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_y", y, 32'd0);
        @(negedge clk);
        rstn = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_reset_no_stale", {31'd0, out_valid}, 32'd0);
        end
        x = 32'h40C0_0000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_reset_lat1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("post_reset_valid", {31'd0, out_valid}, 32'd1);
        check("post_reset_y", y, 32'd6);

        // Random stream with random stalls and bubbles.
        for (int c = 0; c < 604; c++) begin
            @(negedge clk);
            if (!stall && out_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rand_unexpected: got y=%h expected no output", y);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("rand_y", y, r.y);
                    check("rand_nv", {31'd0, nv}, {31'd0, r.nv});
                    check("rand_nx", {31'd0, nx}, {31'd0, r.nx});
                end
            end
            if (c < 600) begin
                stall    = ($urandom_range(0, 3) == 0);
                in_valid = $urandom_range(0, 1) == 1;
                x        = gen_x();
                rm       = 3'($urandom_range(0, 7));
            end else begin
                stall = 1'b0; in_valid = 1'b0;
            end
            if (!stall && in_valid) begin
                res_t r;
                ref_model(x, rm, r.y, r.nv, r.nx);
                exp_q.push_back(r);
            end
        end
        check("rand_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fcvt_w_s_pipe.md
Name: fcvt_w_s_pipe

Overview:
- Pipelined single-precision float to signed 32-bit integer converter (RISC-V FCVT.W.S).
- Inverse direction of the FPU's int-to-float converter. Sits in the FPU pipeline alongside it.
- Supports all five static rounding modes. Produces RISC-V saturating results and NV/NX flags.
- Latency 2 cycles; full throughput; global stall.

Parameters:
- none; widths are fixed at 32-bit input and 32-bit output.

Ports:
- clk        input   1   clock; all registers update on rising edge
- rstn       input   1   reset, asynchronous, active-low
- x          input   32  IEEE-754 binary32 operand
- rm         input   3   rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
- in_valid   input   1   x/rm valid this cycle
- stall      input   1   when 1, every pipeline register (data and valid) holds
- y          output  32  signed integer result, registered
- out_valid  output  1   y/nv/nx valid
- nv         output  1   invalid flag (NaN, infinity, out of range)
- nx         output  1   inexact flag

Behaviour:
- Reset (rstn=0, asynchronous): y=0, nv=0, nx=0, out_valid=0, stage-1 valid=0, all stage-1 registers 0. Takes effect immediately, not at the next edge. Any in-flight operation is discarded. First capture is on the first rising edge with rstn=1.
- Pipeline: operand accepted on edge k when stall=0 (regardless of in_valid; the valid bit travels with it). Result is visible after edge k+1 with stall=0, i.e. out_valid=1 two unstalled edges after acceptance.
- Stall: stall=1 freezes both stages, including out_valid and y. No bubble is inserted and nothing is lost. in_valid=0 slots propagate as out_valid=0; y then holds the last computed value (don't-care).
- Stage 1:
  - Unpack s=x[31], e=x[30:23], f=x[22:0].
  - Classify: NaN (e=255, f!=0), Inf (e=255, f=0), zero (e=0, f=0), denormal (e=0, f!=0).
  - Form 24-bit significand {1,f}.
  - If e>=158: overflow candidate. If e>=150: left shift amount e-150. Otherwise: right shift amount 150-e, saturated at 31.
  - Register class bits, s, rm, significand, shift direction/amount.
- Stage 2:
  - Left shift: mag = sig << (e-150), exact, guard=sticky=0.
  - Right shift: mag = sig >> n; guard = bit n-1 of sig; sticky = OR of bits below n-1. For n>=25, mag=0 and guard/sticky come from sig accordingly.
  - Denormal: mag=0, guard=0, sticky=1.
  - Round increment inc by mode:
    - RNE: guard & (sticky | mag[0])
    - RTZ: 0
    - RDN: s & (guard | sticky)
    - RUP: ~s & (guard | sticky)
    - RMM: guard
  - r = mag + inc, computed in 33 bits.
  - Range check: s=0 requires r <= 0x7FFFFFFF; s=1 requires r <= 0x80000000. The exponent e>=158 is out of range except x=0xCF000000 (exactly -2^31), which is in range.
  - Result: y = s ? -r : r (two's complement, 32 bits).
- Specials and saturation (nv=1, nx=0):
  - NaN gives 0x7FFFFFFF.
  - +Inf or positive out of range gives 0x7FFFFFFF.
  - -Inf or negative out of range gives 0x80000000.
- Flags otherwise: nv=0, nx = guard | sticky. Zero (either sign) gives y=0, nv=0, nx=0. Negative values rounding to 0 give y=0, not -0.
- Flags are registered with y and are valid only when out_valid=1.

Test Plan:
- x=0x3FC00000 (1.5), rm=RNE/RTZ/RDN/RUP/RMM -> y=2/1/1/2/2, nx=1, nv=0, out_valid exactly 2 cycles after in_valid.
- x=0xC0200000 (-2.5), rm=RNE/RTZ/RDN/RUP/RMM -> y=0xFFFFFFFE/0xFFFFFFFE/0xFFFFFFFD/0xFFFFFFFE/0xFFFFFFFD, nx=1.
- Boundaries:
  - x=0xCF000000 -> 0x80000000, nv=0, nx=0.
  - x=0x4F000000 -> 0x7FFFFFFF, nv=1.
  - x=0x7FC00000 -> 0x7FFFFFFF, nv=1.
  - x=0xFF800000 -> 0x80000000, nv=1.
  - x=0x4EFFFFFF -> 0x7FFFFF80, nv=0, nx=0.
- Small values:
  - x=0x00000001 with RUP -> 1, nx=1; with RNE -> 0, nx=1.
  - x=0x80000000 -> 0, nx=0.
  - x=0xBF000000 (-0.5) with RDN -> 0xFFFFFFFF; with RNE -> 0, nx=1.
- Throughput and stall: 1.0, 2.0, 3.0 back-to-back, then stall=1 for 3 cycles after the first result. Required: outputs 1, 2, 3 in order with no duplicates or drops, and y/out_valid frozen during the stall.
- Reset mid-stream: drop rstn between clock edges with two ops in flight. Required: out_valid=0 and y=0 immediately. After release, no stale result appears and the next op returns after 2 cycles.
